// File: rtl/cr_ahbl_master_if_if.sv
// AHB-Lite master-side bus bundle for cr_ahbl_master_if.
// The master modport drives the address and write data. The slave modport returns hready, hresp and hrdata.
interface cr_ahbl_master_if_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [1:0]            htrans;
  logic [ADDR_WIDTH-1:0] haddr;
  logic [2:0]            hsize;
  logic [2:0]            hburst;
  logic                  hwrite;
  logic [3:0]            hprot;
  logic [DATA_WIDTH-1:0] hwdata;
  logic                  hready;
  logic                  hresp;
  logic [DATA_WIDTH-1:0] hrdata;

  modport master (
    output htrans, haddr, hsize, hburst, hwrite, hprot, hwdata,
    input  hready, hresp, hrdata
  );

  modport slave (
    input  htrans, haddr, hsize, hburst, hwrite, hprot, hwdata,
    output hready, hresp, hrdata
  );
endinterface

// File: rtl/cr_ahbl_master_if.sv
// Drives the arbitrated CPU request stream onto AHB-Lite as SINGLE transfers.
// One transfer may be in the address phase and one in the data phase. The block holds NONSEQ under wait states and tracks transfer ownership.
module cr_ahbl_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  ahbl_gated_clk,
  input  logic                  cpurst_b,
  input  logic                  cpu_req,
  input  logic                  cpu_req_for_grnt,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [1:0]            cpu_size,
  input  logic                  cpu_write,
  input  logic [3:0]            cpu_prot,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_req_grnt,
  output logic                  cpu_trans_cmplt,
  output logic                  cpu_data_vld,
  output logic                  cpu_acc_err,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  cr_ahbl_master_if_if.master   ahb
);

  typedef enum logic {A_IDLE, A_HOLD} a_state_e;
  typedef enum logic [1:0] {D_NONE, D_OWN, D_ORPH} d_state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [1:0]            size;
    logic                  write;
    logic [3:0]            prot;
  } areq_t;

  a_state_e a_state_q, a_state_d;
  d_state_e d_state_q, d_state_d;
  areq_t    hold_q, hold_d;
  logic     d_write_q, d_write_d;

  areq_t cpu_areq;
  areq_t cur;
  logic  cur_vld;
  logic  issue;
  logic  own_dp;

  assign cpu_areq = {cpu_addr, cpu_size, cpu_write, cpu_prot};

  always_ff @(posedge ahbl_gated_clk) begin
    if (!cpurst_b) begin
      a_state_q <= A_IDLE;
      d_state_q <= D_NONE;
      hold_q    <= '0;
      d_write_q <= 1'b0;
    end else begin
      a_state_q <= a_state_d;
      d_state_q <= d_state_d;
      hold_q    <= hold_d;
      d_write_q <= d_write_d;
    end
  end

  // Address stage. Once NONSEQ is driven under a wait state, it must stay stable until hready, even if the requester withdraws.
  always_comb begin
    a_state_d = a_state_q;
    hold_d    = hold_q;
    cur       = '0;
    cur_vld   = 1'b0;
    if (a_state_q == A_HOLD) begin
      cur     = hold_q;
      cur_vld = 1'b1;
      if (ahb.hready) a_state_d = A_IDLE;
    end else if (cpu_req) begin
      cur     = cpu_areq;
      cur_vld = 1'b1;
      if (!ahb.hready) begin
        a_state_d = A_HOLD;
        hold_d    = cpu_areq;
      end
    end
  end

  assign issue = ahb.hready && cur_vld;

  // Data stage. The slot belongs to the requester only if cpu_req is still present at issue.
  always_comb begin
    d_state_d = d_state_q;
    d_write_d = d_write_q;
    if (ahb.hready) begin
      if (!issue)       d_state_d = D_NONE;
      else if (cpu_req) d_state_d = D_OWN;
      else              d_state_d = D_ORPH;
      d_write_d = issue && cur.write;
    end
  end

  // Bus and responses are forced quiet while reset is held, before the flops clear.
  assign ahb.htrans = (cpurst_b && cur_vld) ? 2'b10 : 2'b00;
  assign ahb.haddr  = cpurst_b ? cur.addr : '0;
  assign ahb.hsize  = cpurst_b ? {1'b0, cur.size} : 3'b000;
  assign ahb.hwrite = cpurst_b && cur.write;
  assign ahb.hprot  = cpurst_b ? cur.prot : 4'h0;
  assign ahb.hburst = 3'b000;

  assign own_dp = cpurst_b && (d_state_q == D_OWN);

  assign ahb.hwdata = (own_dp && d_write_q) ? cpu_wdata : '0;

  assign cpu_req_grnt    = cpurst_b && cpu_req_for_grnt && ahb.hready;
  assign cpu_trans_cmplt = own_dp && ahb.hready;
  assign cpu_data_vld    = own_dp && ahb.hready && !ahb.hresp && !d_write_q;
  assign cpu_acc_err     = own_dp && ahb.hready && ahb.hresp;
  assign cpu_rdata       = ahb.hrdata;

endmodule

// File: tb/tb_cr_ahbl_master_if.sv
// Self-checking bench for cr_ahbl_master_if. It applies directed vectors and a reset-abandon sequence.
// It then runs randomized traffic against a queue-based transaction model.
module tb_cr_ahbl_master_if;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, req, rfg, wr;
  logic [AW-1:0] addr;
  logic [1:0]    size;
  logic [3:0]    prot;
  logic [DW-1:0] wdata;
  logic          grnt, cmplt, dvld, aerr;
  logic [DW-1:0] rdata;

  cr_ahbl_master_if_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  cr_ahbl_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .ahbl_gated_clk   (clk),
    .cpurst_b         (rst_n),
    .cpu_req          (req),
    .cpu_req_for_grnt (rfg),
    .cpu_addr         (addr),
    .cpu_size         (size),
    .cpu_write        (wr),
    .cpu_prot         (prot),
    .cpu_wdata        (wdata),
    .cpu_req_grnt     (grnt),
    .cpu_trans_cmplt  (cmplt),
    .cpu_data_vld     (dvld),
    .cpu_acc_err      (aerr),
    .cpu_rdata        (rdata),
    .ahb              (bus.master)
  );

  int checks = 0;
  int errors = 0;
  string tag;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %0h expected %0h", tag, nm, act, exp);
    end
  endtask

  // When full is 0, only the reset-defined outputs are checked.
  task automatic chk_all(logic [1:0] e_htrans, logic [31:0] e_haddr, logic [2:0] e_hsize,
                         logic e_hwrite, logic [3:0] e_hprot, logic [31:0] e_hwdata,
                         logic e_grnt, logic e_cmplt, logic e_vld, logic e_err, bit full);
    chk("htrans", bus.htrans, e_htrans);
    chk("haddr", bus.haddr, e_haddr);
    chk("grnt", grnt, e_grnt);
    chk("cmplt", cmplt, e_cmplt);
    chk("data_vld", dvld, e_vld);
    chk("acc_err", aerr, e_err);
    chk("hburst", bus.hburst, 3'd0);
    chk("rdata", rdata, bus.hrdata);
    if (full) begin
      chk("hsize", bus.hsize, e_hsize);
      chk("hwrite", bus.hwrite, e_hwrite);
      chk("hprot", bus.hprot, e_hprot);
      chk("hwdata", bus.hwdata, e_hwdata);
    end
  endtask

  typedef struct {
    logic rst_n, req, rfg, wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic hready, hresp;
    logic [31:0] hrdata;
    logic [1:0]  e_htrans;
    logic [31:0] e_haddr;
    logic [2:0]  e_hsize;
    logic        e_hwrite;
    logic [31:0] e_hwdata;
    logic e_grnt, e_cmplt, e_vld, e_err;
  } vec_t;

  function automatic vec_t mk(logic r, logic q, logic g, logic w, logic [31:0] a, logic [1:0] s,
                              logic [31:0] wd, logic hr, logic hs, logic [31:0] rd,
                              logic [1:0] eht, logic [31:0] ea, logic [2:0] es, logic ew,
                              logic [31:0] ewd, logic eg, logic ec, logic ev, logic ee);
    vec_t v;
    v.rst_n = r; v.req = q; v.rfg = g; v.wr = w; v.addr = a; v.size = s; v.wdata = wd;
    v.hready = hr; v.hresp = hs; v.hrdata = rd;
    v.e_htrans = eht; v.e_haddr = ea; v.e_hsize = es; v.e_hwrite = ew; v.e_hwdata = ewd;
    v.e_grnt = eg; v.e_cmplt = ec; v.e_vld = ev; v.e_err = ee;
    return v;
  endfunction

  task automatic drive(logic r, logic q, logic g, logic w, logic [31:0] a, logic [1:0] s,
                       logic [3:0] p, logic [31:0] wd, logic hr, logic hs, logic [31:0] rd);
    rst_n = r; req = q; rfg = g; wr = w; addr = a; size = s; prot = p; wdata = wd;
    bus.hready = hr; bus.hresp = hs; bus.hrdata = rd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        wr;
    logic [3:0]  prot;
    logic        own;
  } xfer_t;

  vec_t  tbl[$];
  xfer_t pend[$];
  xfer_t infl[$];

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    next_cycle();

    // reset with a live request
    tbl.push_back(mk(0,1,1,0,32'h2000_0010,2,0,1,0,0,         0,0,0,0,0,             0,0,0,0));
    tbl.push_back(mk(0,1,1,0,32'h2000_0010,2,0,1,0,0,         0,0,0,0,0,             0,0,0,0));
    // first request after release waits for hready
    tbl.push_back(mk(1,1,1,0,32'h2000_0010,2,0,0,0,0,         2,32'h2000_0010,2,0,0, 0,0,0,0));
    tbl.push_back(mk(1,1,1,0,32'h2000_0010,2,0,1,0,0,         2,32'h2000_0010,2,0,0, 1,0,0,0));
    // completion plus back-to-back zero-wait read
    tbl.push_back(mk(1,1,1,0,32'h2000_0010,2,0,1,0,32'hDEADBEEF, 2,32'h2000_0010,2,0,0, 1,1,1,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,1,0,32'hDEADBEEF,          0,0,0,0,0,             0,1,1,0));
    // write with two wait states, read queued
    tbl.push_back(mk(1,1,1,1,32'h100,2,0,1,0,0,               2,32'h100,2,1,0,       1,0,0,0));
    tbl.push_back(mk(1,1,1,0,32'h104,2,32'h55AA00FF,0,0,0,    2,32'h104,2,0,32'h55AA00FF, 0,0,0,0));
    tbl.push_back(mk(1,1,1,0,32'h104,2,32'h55AA00FF,0,0,0,    2,32'h104,2,0,32'h55AA00FF, 0,0,0,0));
    tbl.push_back(mk(1,1,1,0,32'h104,2,32'h55AA00FF,1,0,0,    2,32'h104,2,0,32'h55AA00FF, 1,1,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,32'h55AA00FF,1,0,32'h12345678, 0,0,0,0,0,           0,1,1,0));
    // NONSEQ hold then withdrawal becomes an orphan
    tbl.push_back(mk(1,1,1,0,32'h200,1,0,0,0,0,               2,32'h200,1,0,0,       0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,                     2,32'h200,1,0,0,       0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,                     2,32'h200,1,0,0,       0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,1,0,0,                     2,32'h200,1,0,0,       0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,1,0,32'hAAAA5555,          0,0,0,0,0,             0,0,0,0));
    // two-cycle ERROR on an owned read
    tbl.push_back(mk(1,1,1,0,32'h300,0,0,1,0,0,               2,32'h300,0,0,0,       1,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0,                     0,0,0,0,0,             0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,1,1,0,                     0,0,0,0,0,             0,1,0,1));
    // denied slot, then hresp in an empty data phase
    tbl.push_back(mk(1,0,1,0,0,0,0,1,0,0,                     0,0,0,0,0,             1,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,1,1,0,                     0,0,0,0,0,             0,0,0,0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst_n, tbl[i].req, tbl[i].rfg, tbl[i].wr, tbl[i].addr, tbl[i].size, 4'hA,
            tbl[i].wdata, tbl[i].hready, tbl[i].hresp, tbl[i].hrdata);
      #3;
      tag = $sformatf("vec%0d", i);
      chk_all(tbl[i].e_htrans, tbl[i].e_haddr, tbl[i].e_hsize, tbl[i].e_hwrite,
              (tbl[i].e_htrans != 0) ? 4'hA : 4'h0, tbl[i].e_hwdata,
              tbl[i].e_grnt, tbl[i].e_cmplt, tbl[i].e_vld, tbl[i].e_err, tbl[i].rst_n);
      next_cycle();
    end

    // An owned read is in flight when reset arrives. No completion may be reported.
    tag = "rst_abandon";
    drive(1, 1, 1, 0, 32'h400, 2, 4'h1, 0, 1, 0, 0);
    #3 chk("grnt", grnt, 1'b1);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0BAD);
    #3 chk("cmplt", cmplt, 1'b0);
    chk("data_vld", dvld, 1'b0);
    next_cycle();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0BAD);
    #3 chk("cmplt", cmplt, 1'b0);
    chk("htrans", bus.htrans, 2'd0);
    next_cycle();

    // randomized traffic against the transaction model
    begin
      int err_stage;
      err_stage = 0;
      pend.delete();
      infl.delete();
      for (int c = 0; c < 600; c++) begin
        logic r, q, g, w, hr, hs;
        logic [31:0] a, wd, rd;
        logic [1:0] s;
        logic [3:0] p;
        logic cv;
        xfer_t cur, x;
        logic [1:0] e_ht; logic [31:0] e_ha; logic [2:0] e_hs; logic e_hw; logic [3:0] e_hp;
        logic [31:0] e_wd; logic e_g, e_c, e_v, e_e;

        r  = (c < 2) ? 1'b0 : ($urandom_range(0, 63) != 0);
        a  = {$urandom_range(0, 32'hFFFF), 2'b00, 14'h0} | 32'($urandom_range(0, 255) << 2);
        s  = 2'($urandom_range(0, 2));
        w  = 1'($urandom_range(0, 1));
        p  = 4'($urandom_range(0, 15));
        if (pend.size() > 0) begin
          q = pend[0].wr ? 1'b1 : 1'($urandom_range(0, 1));
          a = pend[0].addr; s = pend[0].size; w = pend[0].wr; p = pend[0].prot;
        end else begin
          q = 1'($urandom_range(0, 1));
        end
        g  = q ? 1'b1 : ($urandom_range(0, 2) == 0);
        wd = $urandom;
        rd = $urandom;
        if (err_stage == 1) begin
          hr = 1'b1; hs = 1'b1; err_stage = 0;
        end else if (infl.size() > 0 && $urandom_range(0, 5) == 0) begin
          hr = 1'b0; hs = 1'b1; err_stage = 1;
        end else begin
          hs = 1'b0; hr = ($urandom_range(0, 2) != 0);
        end
        drive(r, q, g, w, a, s, p, wd, hr, hs, rd);

        cv = (pend.size() > 0) || q;
        if (pend.size() > 0) cur = pend[0];
        else begin
          cur.addr = a; cur.size = s; cur.wr = w; cur.prot = p; cur.own = 1'b0;
        end
        e_ht = 0; e_ha = 0; e_hs = 0; e_hw = 0; e_hp = 0; e_wd = 0;
        e_g = 0; e_c = 0; e_v = 0; e_e = 0;
        if (r) begin
          if (cv) begin
            e_ht = 2; e_ha = cur.addr; e_hs = {1'b0, cur.size}; e_hw = cur.wr; e_hp = cur.prot;
          end
          e_g = g && hr;
          if (infl.size() > 0 && infl[0].own) begin
            e_c  = hr;
            e_v  = hr && !hs && !infl[0].wr;
            e_e  = hr && hs;
            e_wd = infl[0].wr ? wd : 32'h0;
          end
        end
        #3;
        tag = $sformatf("rnd%0d", c);
        chk_all(e_ht, e_ha, e_hs, e_hw, e_hp, e_wd, e_g, e_c, e_v, e_e, r);

        if (!r) begin
          pend.delete();
          infl.delete();
        end else if (hr) begin
          infl.delete();
          if (cv) begin
            x = cur; x.own = q;
            infl.push_back(x);
          end
          pend.delete();
        end else if (pend.size() == 0 && q) begin
          x.addr = a; x.size = s; x.wr = w; x.prot = p; x.own = 1'b0;
          pend.push_back(x);
        end
        next_cycle();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cr_ahbl_master_if.md
# cr_ahbl_master_if

Bus-side end of the CPU request interface. It takes the single arbitrated request stream (`cpu_req`, `cpu_addr`, …) and drives it onto the AHB-Lite master port as SINGLE transfers. It returns `cpu_req_grnt`, `cpu_trans_cmplt`, `cpu_data_vld`, `cpu_acc_err` and `cpu_rdata` to the request arbiter. It tracks address phase, data phase, wait states, the AHB-Lite NONSEQ-hold rule and the two-cycle ERROR response. At most one transfer is in address phase and one in data phase, with full pipelining.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width of `cpu_addr`/`haddr`
- DATA_WIDTH, 32, data width of `cpu_wdata`/`cpu_rdata`/`hwdata`/`hrdata`

Ports:
- ahbl_gated_clk  in  1  sole clock, rising edge
- cpurst_b  in  1  reset; synchronous, active-low
- cpu_req  in  1  request needing a bus transfer
- cpu_req_for_grnt  in  1  request needing a grant, including denied requests
- cpu_addr  in  ADDR_WIDTH  transfer address
- cpu_size  in  2  transfer size: 0 = byte, 1 = half, 2 = word
- cpu_write  in  1  1 = write
- cpu_prot  in  4  HPROT value
- cpu_wdata  in  DATA_WIDTH  write data, valid during the data phase
- cpu_req_grnt  out  1  request accepted this cycle
- cpu_trans_cmplt  out  1  owned data phase ends this cycle
- cpu_data_vld  out  1  read data valid
- cpu_acc_err  out  1  owned transfer ended with ERROR
- cpu_rdata  out  DATA_WIDTH  read data
- htrans  out  2  0 = IDLE, 2 = NONSEQ
- haddr  out  ADDR_WIDTH  address
- hsize  out  3  `{1'b0, size}`
- hburst  out  3  constant 0 (SINGLE)
- hwrite  out  1  write strobe
- hprot  out  4  protection
- hwdata  out  DATA_WIDTH  write data
- hready  in  1  transfer done / bus free
- hresp  in  1  1 = ERROR
- hrdata  in  DATA_WIDTH  read data

## Operation

**Address stage** has two states, A_IDLE and A_HOLD.
- A_IDLE:
  - Address outputs are driven combinationally from `cpu_*` while `cpu_req` = 1. Otherwise `htrans` = IDLE and `haddr`/`hsize`/`hwrite`/`hprot` = 0.
  - If `cpu_req` = 1 and `hready` = 0, capture addr/size/write/prot into the hold register and go to A_HOLD.
- A_HOLD:
  - Drive NONSEQ from the hold register regardless of `cpu_req`.
  - When `hready` = 1, go to A_IDLE.

**Grant.** `cpu_req_grnt = cpu_req_for_grnt && hready`. A transfer is issued in the cycle where `hready` = 1 and either state = A_HOLD, or state = A_IDLE with `cpu_req` = 1.
- The issued transfer is OWNED if `cpu_req` = 1 in the issue cycle.
- Otherwise it is ORPHAN: the requester withdrew, or the requester is denied (`cpu_req_for_grnt` = 1, `cpu_req` = 0).
- A denied request with no pending transfer is granted and causes no bus activity.

**Data stage** has three states, D_NONE, D_OWN and D_ORPH. It is loaded on every `hready` = 1 edge from the issue result, together with the write flag.
- D_OWN:
  - `cpu_trans_cmplt = hready`.
  - `cpu_data_vld = hready && !hresp && !write`.
  - `cpu_acc_err = hready && hresp`.
- D_ORPH: all responses are suppressed, and `hwdata` = 0.
- D_NONE or read: `hwdata` = 0. For an owned write, `hwdata = cpu_wdata`.
- `cpu_rdata = hrdata` at all times.

**ERROR handling.**
- Cycle 1 (`hresp` = 1, `hready` = 0) is treated as a wait state. Any pending address is held; cancellation is not performed.
- Cycle 2 (`hresp` = 1, `hready` = 1) completes the transfer with `cpu_acc_err`.
- If `hresp` = 1 arrives in D_NONE, it is ignored.

**Requester contract.** Write requests are never withdrawn before grant, so orphan transfers are reads or denied slots only.

## Timing
- Reset (`cpurst_b` = 0 at a rising edge): A_IDLE, D_NONE, hold register cleared.
  - Registered outputs are 0 next cycle; `htrans`, `haddr` and responses go to 0 while reset is held.
  - A transfer in flight is abandoned and no completion is reported.
- Grant latency: 0 cycles, combinational in the issue cycle.
- Data phase starts the cycle after issue. Zero-wait completion arrives 1 cycle after grant; each `hready` = 0 cycle adds 1.
- Back-to-back: issue of B is allowed in A's completing cycle. The arbiter's grant register switches to B at that edge, and A's responses are sampled before it.
- Simultaneous events:
  - Grant and completion in the same cycle is legal.
  - A_HOLD with `hready` = 1 and `cpu_req` = 1 counts as an owned issue of the held transfer. The requester re-presents an identical request.

## Test plan
- Reset: assert `cpurst_b` = 0 with `cpu_req` = 1 -> `htrans` = 0, `haddr` = 0, `cpu_req_grnt` = 0, and all responses 0. Release -> the first issue occurs on the first `hready` = 1 cycle.
- Zero-wait read: `cpu_req`, addr 0x2000_0010, size 2, `hready` = 1 -> same cycle `htrans` = 2, `hsize` = 2, grant = 1. Next cycle `hrdata` = 0xDEADBEEF -> `cpu_data_vld` = 1, `cpu_trans_cmplt` = 1, `cpu_rdata` = 0xDEADBEEF.
- Pipelined write then read: write 0x55AA00FF to 0x100 with 2 wait states, read 0x104 queued -> the read is granted in the write's completion cycle, `hwdata` = 0x55AA00FF for the whole data phase, then the read completes 1 cycle later.
- NONSEQ hold/orphan: `cpu_req` read to 0x200 with `hready` = 0, `cpu_req` drops the next cycle -> `haddr` = 0x200 and `htrans` = 2 held until `hready` = 1, no grant, and no `cpu_trans_cmplt` in the data phase.
- ERROR: an owned read gets `hresp` = 1/`hready` = 0, then `hresp` = 1/`hready` = 1 -> only cycle 2 gives `cpu_trans_cmplt` = 1 and `cpu_acc_err` = 1, with `cpu_data_vld` = 0 throughout.
- Denied slot: `cpu_req_for_grnt` = 1, `cpu_req` = 0, `hready` = 1 -> grant = 1, `htrans` = 0, and no response the next cycle.
